video_timing_pattern_gen: RTL and testbench

Parametrised raster timing and test-pattern source for the HDMI output path. It runs on the pixel clock and produces sync, data-enable, pixel coordinates and 24-bit RGB for the three TMDS channel encoders. It replaces the fixed 858×525 counter and solid-red generator with configurable geometry, configurable sync polarity and four selectable patterns. Mode changes take effect only on frame boundaries.

---
 rtl/video_timing_pattern_gen.sv | 185 ++++++++++++++++++
 tb/tb_video_timing_pattern_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen
// Raster timing and test-pattern source on the pixel clock. A free-running
// (cx, cy) counter pair walks the full raster. Everything that describes the
// current counter position is derived combinationally and registered once,
// so all outputs share one cycle of latency and stay mutually aligned.
//
// Ports:
//   pixclk        pixel clock
//   resetn        asynchronous active-low reset
//   mode[1:0]     0 solid, 1 colour bars, 2 grey ramp, 3 scrolling checkerboard
//   solid_rgb     {R,G,B} colour for mode 0
//   hsync, vsync  syncs, asserted level set by HSYNC_POL / VSYNC_POL
//   de            data enable (active video)
//   pixel_x/y     coordinates of the pixel currently on the outputs
//   red/green/blue pixel colour, zero outside active video
//   frame_start   one-cycle pulse with pixel (0,0)
module video_timing_pattern_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 45,
  parameter int   H_SYNC    = 64,
  parameter int   H_TOTAL   = 858,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 4,
  parameter int   V_SYNC    = 3,
  parameter int   V_TOTAL   = 525,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CW        = 12
) (
  input  logic          pixclk,
  input  logic          resetn,
  input  logic [1:0]    mode,
  input  logic [23:0]   solid_rgb,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          frame_start
);

  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int VS0 = V_ACTIVE + V_FP;
  localparam int BW  = H_ACTIVE / 8;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] HA_C   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA_C   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HT_M1  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VT_M1  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS0_C  = CW'(HS0);
  localparam logic [CW-1:0] HS1_C  = CW'(HS0 + H_SYNC);
  localparam logic [CW-1:0] VS0_C  = CW'(VS0);
  localparam logic [CW-1:0] VS1_C  = CW'(VS0 + V_SYNC);
  localparam logic [CW-1:0] BW_M1  = CW'(BW - 1);

  logic [CW-1:0] cx, cy;
  logic [CW-1:0] bar_cnt;     // position inside the current colour bar
  logic [2:0]    bar_idx;     // bar that cx currently falls in
  logic [7:0]    frame_cnt;
  logic [7:0]    scroll_q;    // frame_cnt value belonging to the frame being drawn
  logic [1:0]    mode_q;
  logic [23:0]   rgb_q;

  logic          at_origin, line_end;
  logic [1:0]    eff_mode;
  logic [23:0]   eff_rgb;
  logic [7:0]    eff_scroll;
  logic          de_c, hs_c, vs_c, chk_c;
  logic [2:0]    bar_bits;
  logic [23:0]   bar_rgb, pix_c;

  assign at_origin = (cx == '0) && (cy == '0);
  assign line_end  = (cx == HT_M1);

  // The shadow registers load on the origin edge, so the origin pixel itself
  // must see the live inputs for a new setting to cover the whole frame.
  assign eff_mode   = at_origin ? mode      : mode_q;
  assign eff_rgb    = at_origin ? solid_rgb : rgb_q;
  assign eff_scroll = at_origin ? frame_cnt : scroll_q;

  assign de_c = (cx < HA_C) && (cy < VA_C);
  assign hs_c = (cx >= HS0_C) && (cx < HS1_C);
  // vsync edges line up with the hsync leading edge of the first and
  // one-past-last sync lines.
  assign vs_c = ((cy == VS0_C) && (cx >= HS0_C)) ||
                ((cy > VS0_C) && (cy < VS1_C)) ||
                ((cy == VS1_C) && (cx < HS0_C));
  // Bit 4 of (cx + scroll) is set exactly when the 5-bit truncated sum >= 16.
  assign chk_c = ((cx[4:0] + eff_scroll[4:0]) >= 5'd16) ^ cy[4];

  always_comb begin
    bar_bits = 3'b000;
    case (bar_idx)
      3'd0: bar_bits = 3'b111;  // white
      3'd1: bar_bits = 3'b110;  // yellow
      3'd2: bar_bits = 3'b011;  // cyan
      3'd3: bar_bits = 3'b010;  // green
      3'd4: bar_bits = 3'b101;  // magenta
      3'd5: bar_bits = 3'b100;  // red
      3'd6: bar_bits = 3'b001;  // blue
      default: bar_bits = 3'b000;  // black
    endcase
    bar_rgb = {{8{bar_bits[2]}}, {8{bar_bits[1]}}, {8{bar_bits[0]}}};
  end

  always_comb begin
    pix_c = 24'h000000;
    if (de_c) begin
      case (eff_mode)
        2'd0:    pix_c = eff_rgb;
        2'd1:    pix_c = bar_rgb;
        2'd2:    pix_c = {3{cx[7:0]}};
        default: pix_c = chk_c ? 24'hFFFFFF : 24'h000000;
      endcase
    end
  end

  // Raster counters, bar tracker and frame-latched state.
  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      cx        <= '0;
      cy        <= '0;
      bar_cnt   <= '0;
      bar_idx   <= 3'd0;
      frame_cnt <= 8'd0;
      scroll_q  <= 8'd0;
      mode_q    <= 2'd0;
      rgb_q     <= 24'h000000;
    end else begin
      if (line_end) begin
        cx <= '0;
        cy <= (cy == VT_M1) ? '0 : cy + ONE;
      end else begin
        cx <= cx + ONE;
      end

      // Bar index follows cx: restarts with the line, steps every BW pixels,
      // and sticks at 7 so the last bar takes the remainder.
      if (line_end) begin
        bar_cnt <= '0;
        bar_idx <= 3'd0;
      end else if (bar_cnt == BW_M1) begin
        bar_cnt <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + ONE;
      end

      if (at_origin) begin
        mode_q    <= mode;
        rgb_q     <= solid_rgb;
        scroll_q  <= frame_cnt;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Single output register stage; every output describes the same (cx, cy).
  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      red         <= 8'd0;
      green       <= 8'd0;
      blue        <= 8'd0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_c ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_c ? VSYNC_POL : ~VSYNC_POL;
      de          <= de_c;
      pixel_x     <= cx;
      pixel_y     <= cy;
      {red, green, blue} <= pix_c;
      frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen. Two instances with small geometries keep
// frames short: "b" exercises sync geometry, bars, latching, random mode
// changes and a mid-frame reset; "s" is tiny and runs the checkerboard long
// enough for frame_cnt to wrap. Expected pixels come from a raster-position
// model: linear output index k -> (x, y, frame) by division.
module tb_video_timing_pattern_gen;

  localparam int   BHA = 42, BHFP = 5, BHSW = 6, BHT = 60;
  localparam int   BVA = 20, BVFP = 2, BVSW = 3, BVT = 28;
  localparam logic BHP = 1'b1, BVP = 1'b0;
  localparam int   SHA = 8,  SHFP = 1, SHSW = 2, SHT = 12;
  localparam int   SVA = 4,  SVFP = 1, SVSW = 1, SVT = 7;
  localparam logic SHP = 1'b0, SVP = 1'b1;
  localparam int   W = 52;  // {sync[3:0], x[11:0], y[11:0], rgb[23:0]}

  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
    24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // clock / reset
  logic pixclk = 1'b0;
  logic resetn = 1'b1, resetn_s = 1'b1;
  always #5 pixclk = ~pixclk;

  logic [1:0]  mode_b = 2'd0, mode_s = 2'd3;
  logic [23:0] solid_b = 24'h0, solid_s = 24'h0;
  logic b_hs, b_vs, b_de, b_fs, s_hs, s_vs, s_de, s_fs;
  logic [11:0] b_x, b_y, s_x, s_y;
  logic [7:0]  b_r, b_g, b_bl, s_r, s_g, s_bl;

  video_timing_pattern_gen #(.H_ACTIVE(BHA), .H_FP(BHFP), .H_SYNC(BHSW), .H_TOTAL(BHT),
    .V_ACTIVE(BVA), .V_FP(BVFP), .V_SYNC(BVSW), .V_TOTAL(BVT),
    .HSYNC_POL(BHP), .VSYNC_POL(BVP), .CW(12)) dut_b (
    .pixclk(pixclk), .resetn(resetn), .mode(mode_b), .solid_rgb(solid_b),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .pixel_x(b_x), .pixel_y(b_y),
    .red(b_r), .green(b_g), .blue(b_bl), .frame_start(b_fs));

  video_timing_pattern_gen #(.H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHSW), .H_TOTAL(SHT),
    .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVSW), .V_TOTAL(SVT),
    .HSYNC_POL(SHP), .VSYNC_POL(SVP), .CW(12)) dut_s (
    .pixclk(pixclk), .resetn(resetn_s), .mode(mode_s), .solid_rgb(solid_s),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .pixel_x(s_x), .pixel_y(s_y),
    .red(s_r), .green(s_g), .blue(s_bl), .frame_start(s_fs));

  // scoreboard state
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] exp_q[$];
  longint k_b = 0, k_s = 0;
  logic [1:0]  fm_b = 2'd0, fm_s = 2'd0;
  logic [23:0] frgb_b = 24'h0, frgb_s = 24'h0;
  int hs_cnt_b = 0, de_cnt_b = 0, fs_gap_s = 0;

  // Reference: what should be on the outputs for the k-th output cycle.
  function automatic logic [W-1:0] model(input int ha, hfp, hsw, ht, va, vfp, vsw, vt,
                                         input logic hp, vp, input longint k,
                                         input logic [1:0] md, input logic [23:0] srgb);
    longint fsz, p, vstart, vend;
    int x, y, f, bar;
    logic hs_on, vs_on, de_e;
    logic [23:0] rgb;
    fsz = longint'(ht) * vt;
    p = k % fsz;
    f = int'(k / fsz);
    x = int'(p % ht);
    y = int'(p / ht);
    de_e = (x < ha) && (y < va);
    hs_on = (x >= ha + hfp) && (x < ha + hfp + hsw);
    vstart = longint'(va + vfp) * ht + ha + hfp;
    vend = vstart + longint'(vsw) * ht;
    vs_on = (p >= vstart) && (p < vend);
    rgb = 24'h0;
    if (de_e) begin
      case (md)
        2'd0: rgb = srgb;
        2'd1: begin
          bar = x / (ha / 8);
          if (bar > 7) bar = 7;
          rgb = BAR_RGB[bar];
        end
        2'd2: rgb = {3{8'(x)}};
        default: rgb = (((((x + f % 256) >> 4) & 1) ^ ((y >> 4) & 1)) != 0) ? 24'hFFFFFF : 24'h0;
      endcase
    end
    return {hs_on ? hp : ~hp, vs_on ? vp : ~vp, de_e, p == 0, 12'(x), 12'(y), rgb};
  endfunction

  task automatic cmp(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic cmp_px(input string nm, input logic [3:0] sy, input logic [11:0] x, y,
                        input logic [23:0] rgb, input logic [W-1:0] e);
    cmp({nm, "_sync"}, {20'd0, sy}, {20'd0, e[51:48]});
    cmp({nm, "_x"}, {12'd0, x}, {12'd0, e[47:36]});
    cmp({nm, "_y"}, {12'd0, y}, {12'd0, e[35:24]});
    cmp({nm, "_rgb"}, rgb, e[23:0]);
  endtask

  task automatic check_big();
    logic [W-1:0] e;
    if (!resetn) begin
      cmp_px("b_rst", {b_hs, b_vs, b_de, b_fs}, b_x, b_y, {b_r, b_g, b_bl},
             {~BHP, ~BVP, 2'b00, 48'd0});
      k_b = 0; hs_cnt_b = 0; de_cnt_b = 0;
      return;
    end
    if (k_b % (BHT * BVT) == 0) begin fm_b = mode_b; frgb_b = solid_b; end
    exp_q.push_back(model(BHA, BHFP, BHSW, BHT, BVA, BVFP, BVSW, BVT, BHP, BVP, k_b, fm_b, frgb_b));
    e = exp_q.pop_front();
    cmp_px("b", {b_hs, b_vs, b_de, b_fs}, b_x, b_y, {b_r, b_g, b_bl}, e);
    if (b_hs === BHP) hs_cnt_b++;
    if (b_de === 1'b1) de_cnt_b++;
    if (int'(e[47:36]) == BHT - 1) begin
      cmp("b_hsync_width", 24'(hs_cnt_b), 24'(BHSW));
      hs_cnt_b = 0;
    end
    if (k_b % (BHT * BVT) == BHT * BVT - 1) begin
      cmp("b_de_per_frame", 24'(de_cnt_b), 24'(BHA * BVA));
      de_cnt_b = 0;
    end
    k_b++;
  endtask

  task automatic check_small();
    logic [W-1:0] e;
    if (!resetn_s) begin
      cmp_px("s_rst", {s_hs, s_vs, s_de, s_fs}, s_x, s_y, {s_r, s_g, s_bl},
             {~SHP, ~SVP, 2'b00, 48'd0});
      k_s = 0; fs_gap_s = 0;
      return;
    end
    if (k_s % (SHT * SVT) == 0) begin fm_s = mode_s; frgb_s = solid_s; end
    exp_q.push_back(model(SHA, SHFP, SHSW, SHT, SVA, SVFP, SVSW, SVT, SHP, SVP, k_s, fm_s, frgb_s));
    e = exp_q.pop_front();
    cmp_px("s", {s_hs, s_vs, s_de, s_fs}, s_x, s_y, {s_r, s_g, s_bl}, e);
    if (s_fs === 1'b1 && k_s > 0) begin
      cmp("s_frame_start_period", 24'(fs_gap_s), 24'(SHT * SVT));
      fs_gap_s = 0;
    end
    fs_gap_s++;
    k_s++;
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge pixclk);
    #1;
    check_big();
    check_small();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        mode_b  = 2'($urandom_range(0, 3));
        solid_b = 24'($urandom);
      end
      cycle();
    end
  endtask

  localparam int BF = BHT * BVT;

  initial begin
    // reset, checked asynchronously before any clock edge
    #1;
    resetn = 1'b0; resetn_s = 1'b0;
    #1;
    cmp_px("b_rst_async", {b_hs, b_vs, b_de, b_fs}, b_x, b_y, {b_r, b_g, b_bl},
           {~BHP, ~BVP, 2'b00, 48'd0});
    cmp_px("s_rst_async", {s_hs, s_vs, s_de, s_fs}, s_x, s_y, {s_r, s_g, s_bl},
           {~SHP, ~SVP, 2'b00, 48'd0});
    run(5);
    mode_b = 2'd1;
    resetn = 1'b1; resetn_s = 1'b1;

    // colour bars, two frames
    run(2 * BF);

    // solid colour, switch to ramp mid-frame: takes effect next frame
    mode_b = 2'd0; solid_b = 24'($urandom);
    run(BF + 700);
    mode_b = 2'd2; solid_b = 24'($urandom);
    run(BF - 700 + BF);

    // checkerboard
    mode_b = 2'd3;
    run(4 * BF);

    // random mode / colour changes at random points
    run_rand(8 * BF);

    // mid-frame asynchronous reset
    run(BF / 2 + 37);
    #3;
    resetn = 1'b0;
    #1;
    cmp_px("b_rst_mid", {b_hs, b_vs, b_de, b_fs}, b_x, b_y, {b_r, b_g, b_bl},
           {~BHP, ~BVP, 2'b00, 48'd0});
    run(3);
    mode_b = 2'($urandom_range(0, 3)); solid_b = 24'($urandom);
    resetn = 1'b1;
    run_rand(3 * BF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
